// File: rtl/lr_moment_accumulator_if.sv
// lr_moment_accumulator_if: stub input stream and moment-set output stream of the accumulator
interface lr_moment_accumulator_if #(
  parameter int IN_W   = 16,
  parameter int PROD_W = 32,
  parameter int CNT_W  = 4,
  parameter int GUARD  = 3
);
  logic                    s_valid;
  logic                    s_ready;
  logic                    s_last;
  logic [IN_W-1:0]         s_x;
  logic [IN_W-1:0]         s_y;
  logic [PROD_W-1:0]       s_xx;
  logic [PROD_W-1:0]       s_xy;
  logic                    m_valid;
  logic                    m_ready;
  logic [CNT_W-1:0]        m_n;
  logic [IN_W+GUARD-1:0]   m_sx;
  logic [IN_W+GUARD-1:0]   m_sy;
  logic [PROD_W+GUARD-1:0] m_sxx;
  logic [PROD_W+GUARD-1:0] m_sxy;
  logic                    m_ovf;
  modport slave (
    input  s_valid, s_last, s_x, s_y, s_xx, s_xy, m_ready,
    output s_ready, m_valid, m_n, m_sx, m_sy, m_sxx, m_sxy, m_ovf
  );
  modport master (
    output s_valid, s_last, s_x, s_y, s_xx, s_xy, m_ready,
    input  s_ready, m_valid, m_n, m_sx, m_sy, m_sxx, m_sxy, m_ovf
  );
endinterface

// File: rtl/lr_moment_accumulator.sv
// lr_moment_accumulator: per-track n, sum x, sum y, sum x^2, sum xy over a stub stream
module lr_moment_accumulator #(
  parameter int IN_W      = 16,
  parameter int PROD_W    = 32,
  parameter int MAX_STUBS = 8,
  parameter int CNT_W     = 4,
  parameter int GUARD     = 3
) (
  input logic ap_clk,
  input logic ap_rst_n,
  lr_moment_accumulator_if.slave bus
);
  localparam int AW = IN_W + GUARD;
  localparam int PW = PROD_W + GUARD;
  typedef enum logic {ACC, HOLD} state_t;
  state_t                state_q;
  logic                  rdy_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d, m_n_q;
  logic signed [AW-1:0]  sx_q, sx_d, sy_q, sy_d, m_sx_q, m_sy_q;
  logic signed [PW-1:0]  sxx_q, sxx_d, sxy_q, sxy_d, m_sxx_q, m_sxy_q;
  logic                  ovf_q, ovf_d, m_ovf_q;
  logic                  xfer, add, close;
  assign bus.s_ready = rdy_q & ~((state_q == HOLD) & ~bus.m_ready);
  assign bus.m_valid = state_q == HOLD;
  assign bus.m_n     = m_n_q;
  assign bus.m_sx    = m_sx_q;
  assign bus.m_sy    = m_sy_q;
  assign bus.m_sxx   = m_sxx_q;
  assign bus.m_sxy   = m_sxy_q;
  assign bus.m_ovf   = m_ovf_q;
  // beats beyond MAX_STUBS only mark the track as overflowed
  assign xfer  = bus.s_valid & bus.s_ready;
  assign add   = xfer & (cnt_q != CNT_W'(MAX_STUBS));
  assign close = xfer & bus.s_last;
  assign cnt_d = cnt_q + CNT_W'(add);
  assign sx_d  = sx_q + (add ? {{GUARD{bus.s_x[IN_W-1]}}, bus.s_x} : '0);
  assign sy_d  = sy_q + (add ? {{GUARD{bus.s_y[IN_W-1]}}, bus.s_y} : '0);
  assign sxx_d = sxx_q + (add ? {{GUARD{bus.s_xx[PROD_W-1]}}, bus.s_xx} : '0);
  assign sxy_d = sxy_q + (add ? {{GUARD{bus.s_xy[PROD_W-1]}}, bus.s_xy} : '0);
  assign ovf_d = ovf_q | (xfer & ~add);
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      state_q <= ACC;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      sxx_q   <= '0;
      sxy_q   <= '0;
      ovf_q   <= 1'b0;
      m_n_q   <= '0;
      m_sx_q  <= '0;
      m_sy_q  <= '0;
      m_sxx_q <= '0;
      m_sxy_q <= '0;
      m_ovf_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (close) begin
        state_q <= HOLD;
        m_n_q   <= cnt_d;
        m_sx_q  <= sx_d;
        m_sy_q  <= sy_d;
        m_sxx_q <= sxx_d;
        m_sxy_q <= sxy_d;
        m_ovf_q <= ovf_d;
        cnt_q   <= '0;
        sx_q    <= '0;
        sy_q    <= '0;
        sxx_q   <= '0;
        sxy_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        state_q <= bus.m_ready ? ACC : state_q;
        cnt_q   <= cnt_d;
        sx_q    <= sx_d;
        sy_q    <= sy_d;
        sxx_q   <= sxx_d;
        sxy_q   <= sxy_d;
        ovf_q   <= ovf_d;
      end
    end
endmodule
